// File: rtl/marker_render.sv
// marker_render
//
// Synthetic video source. Renders a square concentric-stripe fiducial
// (BG, B, W, B, W, 2W-wide B centre, W, B, W, B, BG along any row through the
// centre) into a raster pixel stream. One frame is produced per accepted
// start pulse. Output is a valid/ready stream with a two-stage pipeline.
//
// Ports
//   clk_in        pixel clock
//   rst_in        asynchronous, active-high reset
//   start_in      one-cycle pulse, begins a frame when idle
//   cx_in, cy_in  marker centre, latched on accepted start
//   stripe_w_in   stripe width W, latched (and clamped) on accepted start
//   glitch_in     force one pixel in the first right-hand white ring to black
//   ready_in      downstream accepts the current pixel
//   valid_out     rgb_out/hcount_out/vcount_out/sol_out/eof_out hold a pixel
//   rgb_out       pixel colour
//   hcount_out    pixel column
//   vcount_out    pixel row
//   sol_out       first pixel of a row
//   eof_out       last pixel of the frame
//   busy_out      frame in progress
//
// state  | meaning
// IDLE   | waiting for start_in
// SETUP  | building thresholds T1..T5 = k*W, one add per cycle
// ACTIVE | raster walk feeding the pixel pipeline until eof is accepted

module marker_render #(
    parameter int         H_ACTIVE   = 640,
    parameter int         V_ACTIVE   = 480,
    parameter logic [2:0] BG_RGB     = 3'b001,
    parameter int         MAX_STRIPE = 200
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [10:0] cx_in,
    input  logic [10:0] cy_in,
    input  logic [10:0] stripe_w_in,
    input  logic        glitch_in,
    input  logic        ready_in,
    output logic        valid_out,
    output logic [2:0]  rgb_out,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        sol_out,
    output logic        eof_out,
    output logic        busy_out
);

    localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] V_LAST = 11'(V_ACTIVE - 1);
    localparam logic [10:0] MAX_W  = 11'(MAX_STRIPE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [2:0]  setup_cnt;
    logic [10:0] cx_q;
    logic [10:0] cy_q;
    logic [10:0] w_q;
    logic        glitch_q;
    logic [10:0] t1;
    logic [10:0] t2;
    logic [10:0] t3;
    logic [10:0] t4;
    logic [10:0] t5;

    logic [10:0] x_cnt;
    logic [10:0] y_cnt;
    logic        gen_done;

    logic        s1_valid;
    logic [10:0] s1_dx;
    logic [10:0] s1_dy;
    logic [10:0] s1_x;
    logic [10:0] s1_y;
    logic        s1_sol;
    logic        s1_eof;
    logic        s1_hit;

    logic [10:0] w_clamped;
    logic [10:0] dx_now;
    logic [10:0] dy_now;
    logic [10:0] glitch_x;
    logic [10:0] d_max;
    logic [2:0]  colour;
    logic        s2_adv;
    logic        s1_adv;
    logic        gen_fire;
    logic        eof_accept;

    // A zero width would collapse the marker; the upper clamp keeps 5*W in
    // 11 bits.
    always_comb begin
        w_clamped = stripe_w_in;
        if (stripe_w_in == 11'd0) begin
            w_clamped = 11'd1;
        end else if (stripe_w_in > MAX_W) begin
            w_clamped = MAX_W;
        end
    end

    assign s2_adv     = !valid_out || ready_in;
    assign s1_adv     = !s1_valid || s2_adv;
    assign gen_fire   = (state == ACTIVE) && !gen_done && s1_adv;
    assign eof_accept = valid_out && ready_in && eof_out;
    assign busy_out   = (state != IDLE);

    // Left of centre uses cx-1-x so the centre band is 2W wide (cx-W .. cx+W-1).
    assign dx_now   = (x_cnt >= cx_q) ? (x_cnt - cx_q) : (cx_q - 11'd1 - x_cnt);
    assign dy_now   = (y_cnt >= cy_q) ? (y_cnt - cy_q) : (cy_q - 11'd1 - y_cnt);
    assign glitch_x = cx_q + t1 + (w_q >> 1);

    always_comb begin
        d_max = (s1_dx > s1_dy) ? s1_dx : s1_dy;
        if (s1_hit) begin
            colour = 3'b000;
        end else if (d_max < t1) begin
            colour = 3'b000;
        end else if (d_max < t2) begin
            colour = 3'b111;
        end else if (d_max < t3) begin
            colour = 3'b000;
        end else if (d_max < t4) begin
            colour = 3'b111;
        end else if (d_max < t5) begin
            colour = 3'b000;
        end else begin
            colour = BG_RGB;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_in) state_nxt = SETUP;
            SETUP:   if (setup_cnt == 3'd5) state_nxt = ACTIVE;
            ACTIVE:  if (eof_accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            setup_cnt  <= 3'd0;
            cx_q       <= 11'd0;
            cy_q       <= 11'd0;
            w_q        <= 11'd0;
            glitch_q   <= 1'b0;
            t1         <= 11'd0;
            t2         <= 11'd0;
            t3         <= 11'd0;
            t4         <= 11'd0;
            t5         <= 11'd0;
            x_cnt      <= 11'd0;
            y_cnt      <= 11'd0;
            gen_done   <= 1'b0;
            s1_valid   <= 1'b0;
            s1_dx      <= 11'd0;
            s1_dy      <= 11'd0;
            s1_x       <= 11'd0;
            s1_y       <= 11'd0;
            s1_sol     <= 1'b0;
            s1_eof     <= 1'b0;
            s1_hit     <= 1'b0;
            valid_out  <= 1'b0;
            rgb_out    <= 3'b000;
            hcount_out <= 11'd0;
            vcount_out <= 11'd0;
            sol_out    <= 1'b0;
            eof_out    <= 1'b0;
        end else begin
            if (state == IDLE && start_in) begin
                cx_q      <= cx_in;
                cy_q      <= cy_in;
                w_q       <= w_clamped;
                glitch_q  <= glitch_in;
                setup_cnt <= 3'd0;
                x_cnt     <= 11'd0;
                y_cnt     <= 11'd0;
                gen_done  <= 1'b0;
            end

            if (state == SETUP) begin
                setup_cnt <= setup_cnt + 3'd1;
                case (setup_cnt)
                    3'd0:    t1 <= w_q;
                    3'd1:    t2 <= t1 + w_q;
                    3'd2:    t3 <= t2 + w_q;
                    3'd3:    t4 <= t3 + w_q;
                    3'd4:    t5 <= t4 + w_q;
                    default: ;
                endcase
            end

            if (gen_fire) begin
                if (x_cnt == H_LAST) begin
                    x_cnt <= 11'd0;
                    if (y_cnt == V_LAST) begin
                        gen_done <= 1'b1;
                    end else begin
                        y_cnt <= y_cnt + 11'd1;
                    end
                end else begin
                    x_cnt <= x_cnt + 11'd1;
                end
            end

            if (s1_adv) begin
                s1_valid <= gen_fire;
                if (gen_fire) begin
                    s1_dx  <= dx_now;
                    s1_dy  <= dy_now;
                    s1_x   <= x_cnt;
                    s1_y   <= y_cnt;
                    s1_sol <= (x_cnt == 11'd0);
                    s1_eof <= (x_cnt == H_LAST) && (y_cnt == V_LAST);
                    s1_hit <= glitch_q && (x_cnt == glitch_x) && (y_cnt == cy_q);
                end
            end

            // sol/eof are qualified so they never linger once the stream drains.
            if (s2_adv) begin
                valid_out <= s1_valid;
                sol_out   <= s1_valid && s1_sol;
                eof_out   <= s1_valid && s1_eof;
                if (s1_valid) begin
                    rgb_out    <= colour;
                    hcount_out <= s1_x;
                    vcount_out <= s1_y;
                end
            end
        end
    end

endmodule
